// File: rtl/stream_rr_arbiter128_if.sv
// Stream bundle for the four-way 128-bit round-robin merger.
// Slave is the arbiter's view; master is the sources/sink side.
interface stream_rr_arbiter128_if;
    logic [3:0]   s_valid;
    logic [3:0]   s_rdy;
    logic [511:0] s_data;
    logic         m_valid;
    logic         m_rdy;
    logic [127:0] m_data;
    logic [1:0]   m_src;

    modport slave (
        input  s_valid,
        input  s_data,
        input  m_rdy,
        output s_rdy,
        output m_valid,
        output m_data,
        output m_src
    );

    modport master (
        output s_valid,
        output s_data,
        output m_rdy,
        input  s_rdy,
        input  m_valid,
        input  m_data,
        input  m_src
    );
endinterface

// File: rtl/stream_rr_arbiter128.sv
// Four-source round-robin stream merger with bounded bursts,
// a registered output beat and a source tag on every beat.
module stream_rr_arbiter128 #(
    parameter int MAX_BURST = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   src_en,
    stream_rr_arbiter128_if.slave        bus,
    output logic                         busy
);
    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [8:0] BURST = 9'(MAX_BURST);

    state_t       state_q, state_d;
    logic [1:0]   g_q, g_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         empty_q, empty_d;
    logic [127:0] data_q, data_d;
    logic [1:0]   src_q, src_d;

    logic [3:0]   req;
    logic         found;
    logic [1:0]   win;
    logic         sel_valid;
    logic [127:0] slice;
    logic         out_free;
    logic         accept;
    logic         last;
    logic         release_g;

    assign req = bus.s_valid & src_en;

    // Walk from ptr+4 down to ptr+1 so the nearest requester wins last.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                found = 1'b1;
                win   = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        slice     = bus.s_data[127:0];
        sel_valid = bus.s_valid[0];
        unique case (g_q)
            2'd0: begin
                slice     = bus.s_data[127:0];
                sel_valid = bus.s_valid[0];
            end
            2'd1: begin
                slice     = bus.s_data[255:128];
                sel_valid = bus.s_valid[1];
            end
            2'd2: begin
                slice     = bus.s_data[383:256];
                sel_valid = bus.s_valid[2];
            end
            2'd3: begin
                slice     = bus.s_data[511:384];
                sel_valid = bus.s_valid[3];
            end
        endcase
    end

    assign out_free  = empty_q | bus.m_rdy;
    assign accept    = (state_q == GRANT) & sel_valid & out_free;
    assign last      = accept & (({1'b0, cnt_q} + 9'd1) == BURST);
    assign release_g = (state_q == GRANT) & (last | ~sel_valid);

    always_comb begin
        bus.s_rdy = 4'b0000;
        if ((state_q == GRANT) && out_free) begin
            bus.s_rdy[g_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    g_d     = win;
                    cnt_d   = 8'd0;
                end
            end
            GRANT: begin
                if (accept) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (release_g) begin
                    state_d = IDLE;
                    ptr_d   = g_q;
                    cnt_d   = 8'd0;
                end
            end
        endcase
    end

    // A new beat may overwrite the held one only when it is being taken.
    always_comb begin
        empty_d = empty_q;
        data_d  = data_q;
        src_d   = src_q;
        if (accept) begin
            empty_d = 1'b0;
            data_d  = slice;
            src_d   = g_q;
        end else if (bus.m_rdy) begin
            empty_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= 2'd0;
            ptr_q   <= 2'd3;
            cnt_q   <= 8'd0;
            empty_q <= 1'b1;
            data_q  <= '0;
            src_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign bus.m_valid = ~empty_q;
    assign bus.m_data  = data_q;
    assign bus.m_src   = src_q;
    assign busy        = (state_q == GRANT);
endmodule

// File: tb/tb_stream_rr_arbiter128.sv
// Directed bench for stream_rr_arbiter128: burst-16 and burst-1 instances,
// per-source scoreboard queues checked as beats leave the output.
module tb_stream_rr_arbiter128;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src_en;
    logic [3:0] src_en1;
    logic       busy_a;
    logic       busy_b;

    stream_rr_arbiter128_if a();
    stream_rr_arbiter128_if b();

    stream_rr_arbiter128 #(.MAX_BURST(16)) dut (
        .clk(clk), .rst(rst), .src_en(src_en), .bus(a), .busy(busy_a)
    );
    stream_rr_arbiter128 #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .src_en(src_en1), .bus(b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int seq[4], lim[4], seq1[4], lim1[4], nxt1[4];
    logic [127:0] expq[4][$];
    bit lv[$], lb[$], lsv2[$], l1v[$];
    int ls[$], l1s[$];
    bit rnd = 1'b0;
    int pops = 0;
    bit s_v, o_v, s_busy, s_mrdy, o_mrdy;
    int s_src, o_src;
    logic [127:0] s_dat, o_dat;
    logic [3:0] s_srdy;

    function automatic logic [127:0] mk(input int src, input int n);
        return {8'(src), 88'd0, 32'(n)};
    endfunction

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            a.s_valid[i] = (seq[i] < lim[i]);
            a.s_data[i*128 +: 128] = mk(i, seq[i]);
            b.s_valid[i] = (seq1[i] < lim1[i]);
            b.s_data[i*128 +: 128] = mk(i, seq1[i]);
        end
    endtask

    task automatic clear_logs();
        lv.delete(); lb.delete(); lsv2.delete(); ls.delete();
        l1v.delete(); l1s.delete();
    endtask

    task automatic tick();
        logic [3:0] acc, acc1;
        logic [127:0] e;
        @(negedge clk);
        acc  = a.s_valid & a.s_rdy;
        acc1 = b.s_valid & b.s_rdy;
        for (int i = 0; i < 4; i++)
            if (acc[i]) expq[i].push_back(mk(i, seq[i]));
        o_v = s_v; o_src = s_src; o_dat = s_dat; o_mrdy = s_mrdy;
        s_v = a.m_valid; s_src = int'(a.m_src); s_dat = a.m_data;
        s_srdy = a.s_rdy; s_busy = busy_a; s_mrdy = a.m_rdy;
        if (o_v && !o_mrdy) begin
            chki("stall_valid", int'(s_v), 1);
            chk("stall_data", s_dat, o_dat);
            chki("stall_src", s_src, o_src);
        end
        if (s_v && s_mrdy) begin
            pops++;
            chki("sb_nonempty", int'(expq[s_src].size() > 0), 1);
            if (expq[s_src].size() > 0) begin
                e = expq[s_src].pop_front();
                chk("sb_data", s_dat, e);
            end
        end
        if (b.m_valid && b.m_rdy) begin
            chki("u1_seq", int'(b.m_data[31:0]), nxt1[b.m_src]);
            nxt1[b.m_src]++;
        end
        lv.push_back(s_v); ls.push_back(s_src); lb.push_back(s_busy);
        lsv2.push_back(a.s_valid[2]);
        l1v.push_back(b.m_valid); l1s.push_back(int'(b.m_src));
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) seq[i]++;
            if (acc1[i]) seq1[i]++;
        end
        if (rnd) a.m_rdy = 1'($urandom_range(0, 1));
        drive();
    endtask

    task automatic check_drained(input string tag);
        for (int i = 0; i < 4; i++)
            chki(tag, expq[i].size(), 0);
    endtask

    initial begin
        int n2, no, d, f, bad, lead, n3, p0;
        bit st;
        int rs[$], rl[$];
        rst = 1'b1; src_en = 4'hF; src_en1 = 4'b1001;
        a.m_rdy = 1'b1; b.m_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0; lim[i] = 0; seq1[i] = 0; lim1[i] = 0; nxt1[i] = 0;
        end
        s_v = 0; o_v = 0; s_mrdy = 1; o_mrdy = 1; s_src = 0; o_src = 0;
        s_dat = '0; o_dat = '0;
        drive();
        repeat (3) tick();
        chki("rst_m_valid", int'(s_v), 0);
        chki("rst_s_rdy", int'(s_srdy), 0);
        chk("rst_m_data", s_dat, 128'd0);
        chki("rst_m_src", s_src, 0);
        chki("rst_busy", int'(s_busy), 0);
        chki("rst_u1_valid", int'(b.m_valid), 0);

        // full contention, burst 16
        rst = 1'b0;
        for (int i = 0; i < 4; i++) lim[i] = seq[i] + 100000;
        drive();
        clear_logs();
        repeat (87) tick();
        chki("rr_lat0", int'(lv[0]), 0);
        chki("rr_lat1", int'(lv[1]), 0);
        for (int k = 0; k < 85; k++) begin
            chki("rr_valid", int'(lv[k+2]), int'((k % 17) != 16));
            if ((k % 17) != 16) chki("rr_src", ls[k+2], (k / 17) % 4);
        end
        for (int i = 0; i < 4; i++) lim[i] = seq[i];
        drive();
        repeat (6) tick();
        check_drained("rr_drain");

        // lone source 2, five beats
        lim[2] = seq[2] + 5;
        drive();
        clear_logs();
        repeat (15) tick();
        n2 = 0; no = 0;
        foreach (lv[k]) if (lv[k]) begin
            if (ls[k] == 2) n2++; else no++;
        end
        chki("src2_beats", n2, 5);
        chki("src2_other", no, 0);
        d = -1; st = 0;
        foreach (lsv2[k]) begin
            if (lsv2[k]) st = 1;
            else if (st && d < 0) d = k;
        end
        chki("src2_drop_seen", int'(d > 0 && d + 1 < lsv2.size()), 1);
        if (d > 0 && d + 1 < lsv2.size()) begin
            chki("busy_at_drop", int'(lb[d]), 1);
            chki("busy_after_drop", int'(lb[d+1]), 0);
        end
        // ptr now 2: with 2 and 3 requesting, 3 goes first
        lim[2] = seq[2] + 3; lim[3] = seq[3] + 3;
        drive();
        clear_logs();
        repeat (16) tick();
        f = -1;
        foreach (lv[k]) if (lv[k] && f < 0) f = k;
        chki("ptr_first_found", int'(f >= 0), 1);
        if (f >= 0) chki("ptr_after_src2", ls[f], 3);
        repeat (4) tick();
        check_drained("ptr_drain");

        // random backpressure under contention
        for (int i = 0; i < 4; i++) lim[i] = seq[i] + 100000;
        drive();
        p0 = pops;
        rnd = 1'b1;
        repeat (400) tick();
        rnd = 1'b0;
        a.m_rdy = 1'b1;
        for (int i = 0; i < 4; i++) lim[i] = seq[i];
        drive();
        repeat (6) tick();
        chki("bp_progress", int'(pops - p0 > 100), 1);
        check_drained("bp_drain");

        // only sources 1 and 3 enabled
        src_en = 4'b1010;
        for (int i = 0; i < 4; i++) lim[i] = seq[i] + 100000;
        drive();
        clear_logs();
        repeat (80) tick();
        bad = 0;
        foreach (lv[k]) if (lv[k]) begin
            if (!(ls[k] == 1 || ls[k] == 3)) bad++;
            if (k == 0 || !lv[k-1] || ls[k-1] != ls[k]) begin
                rs.push_back(ls[k]); rl.push_back(1);
            end else begin
                n3 = rl.size() - 1;
                rl[n3] = rl[n3] + 1;
            end
        end
        chki("en_mask", bad, 0);
        chki("en_runs", int'(rs.size() >= 3), 1);
        for (int j = 1; j < rs.size(); j++)
            chki("en_alternate", int'(rs[j] != rs[j-1]), 1);
        for (int j = 0; j + 1 < rs.size(); j++)
            chki("en_burst_len", rl[j], 16);
        // clear src_en[1] right after a source-1 grant starts
        st = 0;
        for (int t = 0; t < 100 && !st; t++) begin
            tick();
            if (s_v && s_src == 1 && !(o_v && o_src == 1)) st = 1;
        end
        chki("en_start1_found", int'(st), 1);
        src_en = 4'b1000;
        clear_logs();
        repeat (60) tick();
        lead = 0;
        while (lead < lv.size() && lv[lead] && ls[lead] == 1) lead++;
        chki("en_clear_rest", lead, 15);
        bad = 0; n3 = 0;
        for (int k = lead; k < lv.size(); k++) if (lv[k]) begin
            if (ls[k] == 3) n3++; else bad++;
        end
        chki("en_after_only3", bad, 0);
        chki("en_after_has3", int'(n3 >= 16), 1);

        // reset in the middle of a burst
        src_en = 4'hF;
        drive();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) expq[i].delete();
        s_v = 0;
        tick();
        chki("rst_mid_valid", int'(s_v), 0);
        chki("rst_mid_s_rdy", int'(s_srdy), 0);
        chki("rst_mid_busy", int'(s_busy), 0);
        lim[0] = seq[0];
        rst = 1'b0;
        drive();
        clear_logs();
        repeat (6) tick();
        f = -1;
        foreach (lv[k]) if (lv[k] && f < 0) f = k;
        chki("rst_grant_found", int'(f >= 0), 1);
        if (f >= 0) chki("rst_first_grant", ls[f], 1);
        for (int i = 0; i < 4; i++) lim[i] = seq[i];
        drive();
        repeat (20) tick();
        check_drained("rst_drain");

        // burst-1 instance: sources 0 and 3
        lim1[0] = seq1[0] + 1000; lim1[3] = seq1[3] + 1000;
        drive();
        clear_logs();
        repeat (18) tick();
        chki("b1_lat0", int'(l1v[0]), 0);
        chki("b1_lat1", int'(l1v[1]), 0);
        for (int k = 0; k < 16; k++) begin
            chki("b1_valid", int'(l1v[k+2]), int'(k % 2 == 0));
            if (k % 2 == 0) chki("b1_src", l1s[k+2], ((k / 2) % 2) * 3);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
